ysyx_25030085_ifu: RTL and testbench
====================================

YSYX_25030085_IFU -- requirements
Module: ysyx_25030085_ifu

Interface
REQ-001 Parameter RESET_PC, default 32'h8000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 imem_req_valid  output  1  SHALL signal a fetch request.
REQ-005 imem_req_ready  input  1  SHALL signal that memory accepts the request.
REQ-006 imem_addr  output  32  SHALL carry the fetch address.
REQ-007 imem_rsp_valid  input  1  SHALL signal that imem_rsp_data is valid.
REQ-008 imem_rsp_data  input  32  SHALL carry the fetched instruction word.
REQ-009 inst_valid  output  1  SHALL signal that inst and pc are valid toward the decoder.
REQ-010 inst_ready  input  1  SHALL signal that the decoder consumes inst and pc.
REQ-011 inst  output  32  SHALL carry the instruction word.
REQ-012 pc  output  32  SHALL carry the fetch address of inst.
REQ-013 redirect_valid  input  1  SHALL request a PC change (jal, jalr, taken branch).
REQ-014 redirect_pc  input  32  SHALL carry the redirect target.
REQ-015 fetch_err  output  1  SHALL flag a misaligned redirect (sticky).

Function
REQ-016 FSM states SHALL be IDLE, REQ, WAIT and OUT.
REQ-017 IDLE SHALL go to REQ on the next cycle; first request one cycle after rst deasserts.
REQ-018 In REQ, imem_req_valid=1 and imem_addr=pc_q; on imem_req_ready=1 go to WAIT.
REQ-019 In WAIT, on imem_rsp_valid=1 latch data into inst and go to OUT; inst_valid rises the next cycle (registered).
REQ-020 In OUT, inst_valid=1 and inst/pc SHALL hold stable until inst_ready=1; then pc_q <= pc_q+4 and go to REQ.
REQ-021 PC arithmetic SHALL be 32-bit modulo: 32'hFFFF_FFFC+4 = 32'h0000_0000.
REQ-022 imem_addr SHALL stay stable while imem_req_valid=1 and imem_req_ready=0, except on redirect.
REQ-023 redirect_valid SHALL have priority over every other event: pc_q <= redirect_pc, and go to REQ.
REQ-024 On a redirect in WAIT, or in REQ with imem_req_ready=1 the same cycle, set drop_q.
  - Go to WAIT, discard the next response, clear drop_q, then go to REQ.
REQ-025 On a redirect in OUT (with or without inst_ready), inst_valid SHALL be 0 on the next cycle; no pc+4 update.
REQ-026 imem_rsp_valid in IDLE, REQ or OUT SHALL be ignored.
REQ-027 Only one request SHALL be outstanding at any time.

Reset
REQ-028 On rst=1 at a clock edge:
  - state=IDLE, pc_q=RESET_PC, drop_q=0, fetch_err=0.
  - inst_valid=0, imem_req_valid=0, inst=32'h0000_0013 (nop).
REQ-029 rst mid-transaction SHALL abandon the request and discard any later response for that request.

Configuration
REQ-030 With IFU_ALIGN_CHECK_EN defined, redirect_pc[1:0]!=0 SHALL set fetch_err=1.
  - fetch_err stays 1 until reset.
  - The FSM stays in IDLE and issues no further requests.
REQ-031 Without IFU_ALIGN_CHECK_EN, redirect_pc[1:0] SHALL be forced to 2'b00 and fetch_err SHALL be tied 0.

Structure
REQ-032 The shared package SHALL hold the FSM state enum, RESET_PC default, NOP constant (32'h0000_0013) and the PC increment (4).
REQ-033 The block SHALL be a single module; the PC register/next-PC mux MAY be a sub-module ysyx_25030085_pc_reg.

Verification
REQ-034 Reset release, imem_req_ready=1, rsp in 1 cycle, inst_ready=1 -> addresses 8000_0000, 8000_0004, 8000_0008 in order.
REQ-035 Hold inst_ready=0 for 5 cycles in OUT -> inst/pc stable; no new request; pc advances exactly once after release.
REQ-036 Redirect to 8000_0100 in WAIT -> the old response is dropped (inst_valid stays 0); next imem_addr=8000_0100.
REQ-037 pc_q=FFFF_FFFC, consumed -> next imem_addr=0000_0000.
REQ-038 Redirect to 8000_0102 -> fetch_err=1 with requests halted if IFU_ALIGN_CHECK_EN, else fetch from 8000_0100.
REQ-039 rst asserted in WAIT, then response arrives -> ignored; restart at RESET_PC.

Source files
------------

// File: rtl/ysyx_25030085_ifu_pkg.sv
// Shared types and constants for the ysyx_25030085 instruction fetch unit.
package ysyx_25030085_ifu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_OUT  = 2'd3
  } ifu_state_e;

  localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;
  localparam logic [31:0] IFU_NOP      = 32'h0000_0013;
  localparam logic [31:0] IFU_PC_INC   = 32'd4;

endpackage

// File: rtl/ysyx_25030085_ifu_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, decoder handoff,
// redirect input and error flag. master = the IFU, slave = memory/decoder side.
interface ysyx_25030085_ifu_if;

  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_err;

  modport master (
    output imem_req_valid, imem_addr, inst_valid, inst, pc, fetch_err,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_addr, inst_valid, inst, pc, fetch_err,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
           redirect_valid, redirect_pc
  );

endinterface

// File: rtl/ysyx_25030085_pc_reg.sv
// Fetch PC register with next-PC mux: a redirect load wins over the +4 advance.
module ysyx_25030085_pc_reg
  import ysyx_25030085_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [31:0] load_pc_i,
  input  logic        advance_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_pc_i;
    end else if (advance_i) begin
      pc_d = pc_q + IFU_PC_INC;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/ysyx_25030085_ifu.sv
// Instruction fetch unit: IDLE/REQ/WAIT/OUT FSM, one outstanding request.
// Optional misaligned-redirect trap enabled by defining IFU_ALIGN_CHECK_EN.
module ysyx_25030085_ifu
  import ysyx_25030085_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC
) (
  input logic                        clk,
  input logic                        rst,
  ysyx_25030085_ifu_if.master        bus
);

  ifu_state_e  state_q, state_d;
  logic        drop_q, drop_d;
  logic [31:0] inst_q, inst_d;
  logic        err_q, err_d;
  logic [31:0] pc_q;
  logic        pc_load, pc_advance;
  logic        misalign;
  logic [31:0] redirect_tgt;

  assign redirect_tgt = bus.redirect_pc & ~32'h3;

`ifdef IFU_ALIGN_CHECK_EN
  assign misalign = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  ysyx_25030085_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk       (clk),
    .rst       (rst),
    .load_i    (pc_load),
    .load_pc_i (redirect_tgt),
    .advance_i (pc_advance),
    .pc_o      (pc_q)
  );

  always_comb begin
    state_d    = state_q;
    drop_d     = drop_q;
    inst_d     = inst_q;
    err_d      = err_q;
    pc_load    = 1'b0;
    pc_advance = 1'b0;
    if (err_q) begin
      state_d = S_IDLE;
    end else if (misalign) begin
      err_d   = 1'b1;
      drop_d  = 1'b0;
      state_d = S_IDLE;
    end else if (bus.redirect_valid) begin
      pc_load = 1'b1;
      state_d = S_REQ;
      // A request already accepted by memory must have its response swallowed.
      if (state_q == S_REQ && bus.imem_req_ready) begin
        drop_d  = 1'b1;
        state_d = S_WAIT;
      end else if (state_q == S_WAIT) begin
        drop_d  = !bus.imem_rsp_valid;
        state_d = bus.imem_rsp_valid ? S_REQ : S_WAIT;
      end
    end else begin
      case (state_q)
        S_IDLE: state_d = S_REQ;
        S_REQ:  if (bus.imem_req_ready) state_d = S_WAIT;
        S_WAIT: begin
          if (bus.imem_rsp_valid) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = S_REQ;
            end else begin
              inst_d  = bus.imem_rsp_data;
              state_d = S_OUT;
            end
          end
        end
        S_OUT: begin
          if (bus.inst_ready) begin
            pc_advance = 1'b1;
            state_d    = S_REQ;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      drop_q  <= 1'b0;
      inst_q  <= IFU_NOP;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      inst_q  <= inst_d;
      err_q   <= err_d;
    end
  end

  assign bus.imem_req_valid = (state_q == S_REQ);
  assign bus.imem_addr      = pc_q;
  assign bus.inst_valid     = (state_q == S_OUT);
  assign bus.inst           = inst_q;
  assign bus.pc             = pc_q;
  assign bus.fetch_err      = err_q;

endmodule

// File: tb/tb_ysyx_25030085_ifu.sv
// Directed self-checking bench for ysyx_25030085_ifu.
module tb_ysyx_25030085_ifu;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  ysyx_25030085_ifu_if bus ();

  ysyx_25030085_ifu #(
    .RESET_PC (32'h8000_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full fetch handshake: request, 1-cycle response, consume.
  task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] data);
    int n;
    n = 0;
    while (!bus.imem_req_valid && n < 20) begin
      step();
      n++;
    end
    check("req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
    check("imem_addr", bus.imem_addr, exp_addr);
    bus.imem_req_ready = 1'b1;
    step();
    bus.imem_req_ready = 1'b0;
    check("wait_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = data;
    step();
    bus.imem_rsp_valid = 1'b0;
    check("inst_valid", {31'd0, bus.inst_valid}, 32'd1);
    check("inst", bus.inst, data);
    check("pc", bus.pc, exp_addr);
    bus.inst_ready = 1'b1;
    step();
    bus.inst_ready = 1'b0;
    $display("fetch addr=%h inst=%h", exp_addr, data);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    check("rst_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
    check("rst_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
    check("rst_inst_nop", bus.inst, 32'h0000_0013);
    check("rst_fetch_err", {31'd0, bus.fetch_err}, 32'd0);
    rst = 1'b0;
    step();
    check("first_req", {31'd0, bus.imem_req_valid}, 32'd1);
    check("first_addr", bus.imem_addr, 32'h8000_0000);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;

    do_reset();

    // Sequential fetches
    fetch(32'h8000_0000, 32'h0000_0011);
    fetch(32'h8000_0004, 32'h0000_0022);
    fetch(32'h8000_0008, 32'h0000_0033);

    // Decoder backpressure for 5 cycles
    bus.imem_req_ready = 1'b1;
    step();
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hABCD_0001;
    step();
    bus.imem_rsp_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", {31'd0, bus.inst_valid}, 32'd1);
      check("hold_inst", bus.inst, 32'hABCD_0001);
      check("hold_pc", bus.pc, 32'h8000_000C);
      check("hold_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
      step();
    end
    bus.inst_ready = 1'b1;
    step();
    bus.inst_ready = 1'b0;
    $display("held fetch addr=8000000c released");
    fetch(32'h8000_0010, 32'h0000_0044);

    // Redirect while waiting: old response dropped
    bus.imem_req_ready = 1'b1;
    step();
    bus.imem_req_ready = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0100;
    step();
    bus.redirect_valid = 1'b0;
    check("drop_no_valid0", {31'd0, bus.inst_valid}, 32'd0);
    check("drop_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hDEAD_BEEF;
    step();
    bus.imem_rsp_valid = 1'b0;
    check("drop_no_valid1", {31'd0, bus.inst_valid}, 32'd0);
    check("redir_addr", bus.imem_addr, 32'h8000_0100);
    $display("redirect in WAIT to 80000100");
    fetch(32'h8000_0100, 32'h0000_0055);

    // PC wrap
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    step();
    bus.redirect_valid = 1'b0;
    check("wrap_redir_addr", bus.imem_addr, 32'hFFFF_FFFC);
    fetch(32'hFFFF_FFFC, 32'h0000_0066);
    fetch(32'h0000_0000, 32'h0000_0077);

    // Redirect in OUT together with inst_ready: no pc+4
    bus.imem_req_ready = 1'b1;
    step();
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'h0000_0088;
    step();
    bus.imem_rsp_valid = 1'b0;
    check("out_valid", {31'd0, bus.inst_valid}, 32'd1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0200;
    bus.inst_ready     = 1'b1;
    step();
    bus.redirect_valid = 1'b0;
    bus.inst_ready     = 1'b0;
    check("out_redir_valid", {31'd0, bus.inst_valid}, 32'd0);
    check("out_redir_addr", bus.imem_addr, 32'h8000_0200);
    $display("redirect in OUT to 80000200");
    fetch(32'h8000_0200, 32'h0000_0099);

    // Misaligned redirect
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0102;
    step();
    bus.redirect_valid = 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
    for (int i = 0; i < 4; i++) begin
      check("err_flag", {31'd0, bus.fetch_err}, 32'd1);
      check("err_halt", {31'd0, bus.imem_req_valid}, 32'd0);
      step();
    end
    $display("misaligned redirect 80000102 halted fetch");
`else
    check("noerr_flag", {31'd0, bus.fetch_err}, 32'd0);
    check("align_addr", bus.imem_addr, 32'h8000_0100);
    $display("misaligned redirect 80000102 aligned");
    fetch(32'h8000_0100, 32'h0000_00AA);
`endif

    // Reset in WAIT, late response ignored
    do_reset();
    bus.imem_req_ready = 1'b1;
    step();
    bus.imem_req_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hBAD0_BAD0;
    step();
    bus.imem_rsp_valid = 1'b0;
    check("rstw_valid", {31'd0, bus.inst_valid}, 32'd0);
    check("rstw_inst", bus.inst, 32'h0000_0013);
    check("rstw_req", {31'd0, bus.imem_req_valid}, 32'd1);
    check("rstw_addr", bus.imem_addr, 32'h8000_0000);
    $display("reset in WAIT, response ignored");
    fetch(32'h8000_0000, 32'h0000_00BB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
